// File: rtl/bist_pkg.sv
// Shared types and defaults for the logic-BIST sequencer.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } bist_state_t;

  localparam int DEF_SCAN_LEN   = 8;
  localparam int DEF_N_PATTERNS = 4;
  localparam int DEF_SIG_W      = 4;
  localparam int ERRCNT_W       = 8;

endpackage

// File: rtl/bist_sequencer_if.sv
// Control/response bundle between the BIST sequencer and the LFSR/scan/MISR datapath.
interface bist_sequencer_if #(
  parameter int SIG_W = 4
);
  logic             scan_en;
  logic             lfsr_en;
  logic             misr_clr;
  logic             misr_en;
  logic [SIG_W-1:0] misr_sig;

  modport master (
    output scan_en, lfsr_en, misr_clr, misr_en,
    input  misr_sig
  );

  modport slave (
    input  scan_en, lfsr_en, misr_clr, misr_en,
    output misr_sig
  );
endinterface

// File: rtl/bist_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag at TC_VAL.
module bist_counter #(
  parameter int          W      = 4,
  parameter int unsigned TC_VAL = 7
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == W'(TC_VAL));

endmodule

// File: rtl/bist_sequencer.sv
// Logic-BIST run sequencer: MISR clear, shift/capture patterns, signature compare.
// Optional failed-run counter enabled by defining BIST_ERRCNT_EN.
//
// state   | meaning
// IDLE    | waiting for bist_start
// INIT    | clear MISR and counters (1 cycle)
// SHIFT   | scan shift, SCAN_LEN cycles
// CAPTURE | capture cycle, then next pattern or compare
// COMPARE | register signature match
// DONE    | result held until bist_start drops
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int               SCAN_LEN   = DEF_SCAN_LEN,
  parameter int               N_PATTERNS = DEF_N_PATTERNS,
  parameter int               SIG_W      = DEF_SIG_W,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             bist_start,
  input  logic             bist_abort,
  bist_sequencer_if.master dp,
  output logic             running,
  output logic             bist_end,
  output logic             pass_fail
`ifdef BIST_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  bist_state_t state, state_nxt;
  logic shift_clr, shift_en, shift_tc;
  logic pat_clr, pat_en, pat_tc;
  logic abort_run, sig_match;

  assign abort_run = bist_abort && (state != IDLE);
  assign sig_match = (dp.misr_sig == GOLDEN_SIG);

  bist_counter #(.W($clog2(SCAN_LEN + 1)), .TC_VAL(SCAN_LEN - 1)) u_shift_cnt (
    .CLK(CLK), .RST(RST), .clr(shift_clr), .en(shift_en), .tc(shift_tc)
  );

  bist_counter #(.W($clog2(N_PATTERNS + 1)), .TC_VAL(N_PATTERNS - 1)) u_pat_cnt (
    .CLK(CLK), .RST(RST), .clr(pat_clr), .en(pat_en), .tc(pat_tc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_clr = 1'b0;
    shift_en  = 1'b0;
    pat_clr   = 1'b0;
    pat_en    = 1'b0;
    if (abort_run) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bist_start && !bist_abort) state_nxt = INIT;
        INIT: begin
          shift_clr = 1'b1;
          pat_clr   = 1'b1;
          state_nxt = SHIFT;
        end
        SHIFT: begin
          shift_en = 1'b1;
          // Clearing at terminal count leaves the counter at 0 for the next burst.
          if (shift_tc) begin
            shift_clr = 1'b1;
            state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          if (pat_tc) begin
            state_nxt = COMPARE;
          end else begin
            pat_en    = 1'b1;
            state_nxt = SHIFT;
          end
        end
        COMPARE: state_nxt = DONE;
        DONE:    if (!bist_start) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign dp.scan_en  = (state == SHIFT);
  assign dp.lfsr_en  = (state == SHIFT) || (state == CAPTURE);
  assign dp.misr_en  = (state == SHIFT) || (state == CAPTURE);
  assign dp.misr_clr = (state == INIT);
  assign running     = (state == INIT) || (state == SHIFT) ||
                       (state == CAPTURE) || (state == COMPARE);
  assign bist_end    = (state == DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                  pass_fail <= 1'b0;
    else if (abort_run)        pass_fail <= 1'b0;
    else if (state == INIT)    pass_fail <= 1'b0;
    else if (state == COMPARE) pass_fail <= sig_match;
  end

`ifdef BIST_ERRCNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt <= '0;
    end else if (state == COMPARE && !abort_run && !sig_match && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: run table plus abort, reset and hold corner cases.
module tb_bist_sequencer;
  import bist_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  logic bist_start;
  logic bist_abort;
  logic running;
  logic bist_end;
  logic pass_fail;
`ifdef BIST_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bist_sequencer_if #(.SIG_W(4)) dp ();

  bist_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .bist_start (bist_start),
    .bist_abort (bist_abort),
    .dp         (dp),
    .running    (running),
    .bist_end   (bist_end),
    .pass_fail  (pass_fail)
`ifdef BIST_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] sig;
    int         hold_extra;
    logic       exp_pf;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {dp.scan_en, dp.lfsr_en, dp.misr_clr, dp.misr_en, running, bist_end, pass_fail};
  endfunction

  // Start is applied just after edge k; counts are edges from k.
  task automatic run_bist(input string tag, input logic [3:0] sig, input int hold_extra,
                          input logic exp_pf);
    int lat, bursts, cur, bad, reinit, held_bad;
    logic pf_mid;
    lat = 0; bursts = 0; cur = 0; bad = 0; reinit = 0; held_bad = 0; pf_mid = 1'b1;
    dp.misr_sig = sig;
    bist_start  = 1'b1;
    step();
    lat = 1;
    chk({tag, "_init"}, {29'd0, dp.misr_clr, running, dp.scan_en}, 32'b110);
    while (!bist_end && lat < 100) begin
      step();
      lat++;
      if (lat == 2) pf_mid = pass_fail;
      if (dp.misr_clr) reinit++;
      if (dp.scan_en) cur++;
      else if (cur != 0) begin
        bursts++;
        if (cur != 8) bad++;
        cur = 0;
      end
    end
    chk({tag, "_latency"}, lat, 39);
    chk({tag, "_bursts"}, bursts, 4);
    chk({tag, "_burst_len"}, bad, 0);
    chk({tag, "_reinit"}, reinit, 0);
    chk({tag, "_pf_cleared"}, {31'd0, pf_mid}, 0);
    chk({tag, "_pass_fail"}, {31'd0, pass_fail}, {31'd0, exp_pf});
    if (hold_extra > 0) begin
      for (int i = 0; i < hold_extra; i++) begin
        step();
        if (!bist_end || running || dp.misr_clr) held_bad++;
      end
      chk({tag, "_held_done"}, held_bad, 0);
    end
    bist_start = 1'b0;
    step();
    chk({tag, "_to_idle"}, {30'd0, bist_end, running}, 0);
    chk({tag, "_pf_retained"}, {31'd0, pass_fail}, {31'd0, exp_pf});
  endtask

  initial begin
    int rises, guard;
    logic prev;

    vecs[0] = '{4'b0000, 0, 1'b1, 0};
    vecs[1] = '{4'b1010, 0, 1'b0, 1};
    vecs[2] = '{4'b0001, 0, 1'b0, 2};
    vecs[3] = '{4'b0000, 5, 1'b1, 2};
    vecs[4] = '{4'b1000, 0, 1'b0, 3};

    RST = 1'b0;
    bist_start = 1'b0;
    bist_abort = 1'b0;
    dp.misr_sig = 4'b0000;
    #3;
    chk("reset_outs_async", {25'd0, outs()}, 0);
    step();
    step();
    @(negedge CLK);
    RST = 1'b1;
    step();
    chk("reset_outs", {25'd0, outs()}, 0);
`ifdef BIST_ERRCNT_EN
    chk("reset_err_cnt", {24'd0, err_cnt}, 0);
`endif

    bist_start = 1'b1;
    bist_abort = 1'b1;
    step();
    chk("start_abort_idle", {25'd0, outs()}, 0);
    bist_start = 1'b0;
    bist_abort = 1'b0;
    step();

    for (int v = 0; v < 5; v++) begin
      run_bist($sformatf("vec%0d", v), vecs[v].sig, vecs[v].hold_extra, vecs[v].exp_pf);
`ifdef BIST_ERRCNT_EN
      chk($sformatf("vec%0d_err_cnt", v), {24'd0, err_cnt}, vecs[v].exp_err);
`endif
    end

    // Abort inside the second shift burst.
    dp.misr_sig = 4'b0000;
    bist_start = 1'b1;
    rises = 0; guard = 0; prev = 1'b0;
    while (rises < 2 && guard < 100) begin
      step();
      guard++;
      if (dp.scan_en && !prev) rises++;
      prev = dp.scan_en;
    end
    chk("abort_reach_burst2", rises, 2);
    step();
    step();
    chk("abort_in_shift", {31'd0, dp.scan_en}, 1);
    bist_abort = 1'b1;
    bist_start = 1'b0;
    step();
    bist_abort = 1'b0;
    chk("abort_outs", {25'd0, outs()}, 0);
    guard = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bist_end || running) guard++;
    end
    chk("abort_stays_idle", guard, 0);
`ifdef BIST_ERRCNT_EN
    chk("abort_err_cnt", {24'd0, err_cnt}, 3);
`endif

    // Reset asserted in a CAPTURE cycle.
    bist_start = 1'b1;
    guard = 0;
    while (!(dp.lfsr_en && !dp.scan_en) && guard < 100) begin
      step();
      guard++;
    end
    chk("rst_reach_capture", {30'd0, dp.lfsr_en, dp.scan_en}, 32'b10);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_mid_capture_outs", {25'd0, outs()}, 0);
    bist_start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    step();
    run_bist("post_rst", 4'b0000, 0, 1'b1);

`ifdef BIST_ERRCNT_EN
    chk("post_rst_err_cnt", {24'd0, err_cnt}, 0);
    for (int i = 0; i < 256; i++) begin
      run_bist($sformatf("sat%0d", i), 4'b1111, 0, 1'b0);
      if (i == 253) chk("sat_254", {24'd0, err_cnt}, 254);
      if (i == 254) chk("sat_255", {24'd0, err_cnt}, 255);
    end
    chk("sat_hold_255", {24'd0, err_cnt}, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
